// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and default widths.
// Used by both the transmit and receive paths so loopback setups agree on format.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_W_DEFAULT     = 8;
    localparam int PRESCALE_W_DEFAULT = 6;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: per-bit edge counter with clamped prescale,
// bit_done strobe on the last cycle of each bit, and the data bit index.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
    localparam int IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  run,
    input  logic                  in_data,
    output logic                  bit_done,
    output logic [IDX_W-1:0]      bit_idx
);

    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] count;

    assign bit_done = run && (count == period - 1'b1);

    // A bit period below 2 cycles is not supported, so it is widened to 2 at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period  <= '0;
            count   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            period  <= (prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : prescale;
            count   <= '0;
            bit_idx <= '0;
        end else if (run) begin
            if (bit_done) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (bit_done && in_data) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes one byte per accept as start, data (LSB first),
// optional parity and stop. Optional macro UART_TX_TWO_STOP_EN adds a stop2 input.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  stop2,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_state_t       state, state_n;
    logic              tx_n, busy_n;
    logic [DATA_W-1:0] shift_reg, shift_n;
    logic              parity_bit, parity_n;
    logic              par_en_reg, par_en_n;
    logic              load;
    logic              bit_done;
    logic [IDX_W-1:0]  bit_idx;
`ifdef UART_TX_TWO_STOP_EN
    logic              stop2_reg, stop2_n;
    logic              stop_second, stop_second_n;
`endif

    uart_tx_bit_timer #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .prescale (prescale),
        .run      (state != IDLE),
        .in_data  (state == DATA),
        .bit_done (bit_done),
        .bit_idx  (bit_idx)
    );

    // tx_out is registered; its next value is chosen only on accept or bit_done.
    always_comb begin
        state_n  = state;
        tx_n     = tx_out;
        busy_n   = busy;
        shift_n  = shift_reg;
        parity_n = parity_bit;
        par_en_n = par_en_reg;
        load     = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop2_n       = stop2_reg;
        stop_second_n = stop_second;
`endif
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (data_valid) begin
                    load     = 1'b1;
                    state_n  = START;
                    tx_n     = 1'b0;
                    busy_n   = 1'b1;
                    shift_n  = p_data;
                    parity_n = (^p_data) ^ (par_typ == PAR_ODD);
                    par_en_n = par_en;
`ifdef UART_TX_TWO_STOP_EN
                    stop2_n       = stop2;
                    stop_second_n = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    tx_n    = shift_reg[0];
                    shift_n = shift_reg >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        if (par_en_reg) begin
                            state_n = PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n    = shift_reg[0];
                        shift_n = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop2_reg && !stop_second) begin
                        stop_second_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
`else
                    state_n = IDLE;
                    busy_n  = 1'b0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            par_en_reg <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_reg   <= 1'b0;
            stop_second <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            tx_out     <= tx_n;
            busy       <= busy_n;
            shift_reg  <= shift_n;
            parity_bit <= parity_n;
            par_en_reg <= par_en_n;
`ifdef UART_TX_TWO_STOP_EN
            stop2_reg   <= stop2_n;
            stop_second <= stop_second_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected line levels are queued per frame and
// compared cycle by cycle on the falling clock edge. Covers UART_TX_TWO_STOP_EN when defined.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [DATA_W-1:0]     p_data = '0;
    logic                  data_valid = 1'b0;
    logic                  par_en = 1'b0;
    logic                  par_typ = 1'b0;
    logic [PRESCALE_W-1:0] prescale = '0;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2 = 1'b0;
`endif
    logic                  tx_out;
    logic                  busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    uart_tx_frame #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
`ifdef UART_TX_TWO_STOP_EN
        .stop2      (stop2),
`endif
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, one or two stop bits.
    task automatic push_frame(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                              input int p, input logic s2);
        logic bits[$];
        int   per;
        per = (p < 2) ? 2 : p;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < per; k++) exp_q.push_back(bits[i]);
        end
    endtask

    task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                                  input int p, input logic s2);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = PRESCALE_W'(p);
`ifdef UART_TX_TWO_STOP_EN
        stop2      = s2;
`endif
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        push_frame(d, pe, pt, p, s2);
    endtask

    // Walks the queued frame; optionally pulses a rejected request or starts holding one.
    task automatic check_output(input string tag, input int pulse_at, input int hold_at);
        int   cyc;
        logic expv;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            expv = exp_q.pop_front();
            check_eq({tag, ".tx"}, tx_out, expv);
            check_eq({tag, ".busy"}, busy, 1'b1);
            if (cyc == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'h55;
            end
            if (cyc == pulse_at + 1) data_valid = 1'b0;
            if (cyc == hold_at) begin
                data_valid = 1'b1;
                p_data     = 8'h11;
            end
            cyc++;
        end
        @(negedge clk);
        check_eq({tag, ".end_busy"}, busy, 1'b0);
        check_eq({tag, ".end_tx"}, tx_out, 1'b1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset.tx", tx_out, 1'b1);
        check_eq("reset.busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        apply_stimulus(8'hA5, 1'b0, 1'b0, 8, 1'b0);
        check_output("basic_a5", -1, -1);

        apply_stimulus(8'h03, 1'b1, PAR_EVEN, 4, 1'b0);
        check_output("even_03", -1, -1);

        apply_stimulus(8'h03, 1'b1, PAR_ODD, 4, 1'b0);
        check_output("odd_03", -1, -1);

        apply_stimulus(8'h07, 1'b1, PAR_ODD, 4, 1'b0);
        check_output("odd_07", -1, -1);

        apply_stimulus(8'h3C, 1'b0, 1'b0, 4, 1'b0);
        check_output("handshake_3c", 5, 20);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        push_frame(8'h11, 1'b0, 1'b0, 4, 1'b0);
        check_output("b2b_11", -1, -1);

        apply_stimulus(8'hC3, 1'b0, 1'b0, 4, 1'b0);
        exp_q.delete();
        repeat (17) @(negedge clk);
        check_eq("midrst.pre_tx", tx_out, 1'b0);
        check_eq("midrst.pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.tx", tx_out, 1'b1);
        check_eq("midrst.busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(8'hFF, 1'b1, PAR_EVEN, 4, 1'b0);
        check_output("after_rst_ff", -1, -1);

        apply_stimulus(8'h96, 1'b1, PAR_ODD, 1, 1'b0);
        check_output("clamp_p1", -1, -1);

        apply_stimulus(8'h01, 1'b0, 1'b0, 0, 1'b0);
        check_output("clamp_p0", -1, -1);

`ifdef UART_TX_TWO_STOP_EN
        apply_stimulus(8'hA5, 1'b0, 1'b0, 8, 1'b1);
        check_output("two_stop_a5", -1, -1);
        apply_stimulus(8'h5A, 1'b1, PAR_EVEN, 3, 1'b0);
        check_output("one_stop_5a", -1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
